// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Two-operand adder/subtractor split into STAGES equal chunks of
//   CW = WIDTH/STAGES bits. One chunk is resolved per clock and the carry is
//   registered between stages, so long carry chains never span more than one
//   chunk per cycle. A single global advance (adv) moves or freezes the whole
//   pipe, which keeps bubbles in place and results in acceptance order.
//
// Parameters
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  pipeline depth (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction present
//   in_ready   block accepts input this cycle (= adv)
//   a, b       operands
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin   1: a-b (a+~b+1)
//   out_valid  result present
//   out_ready  downstream accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of MSB (in subtract mode 1 = no borrow)
//   ovf        signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   // Stage k registers: operands (b already conditioned for subtract),
   // partial sum with chunks 0..k filled, carry out of chunk k, valid bit.
   logic [WIDTH-1:0]  r_a [STAGES];
   logic [WIDTH-1:0]  r_b [STAGES];
   logic [WIDTH-1:0]  r_s [STAGES];
   logic [STAGES-1:0] r_c;
   logic [STAGES-1:0] r_v;
   logic              r_ovf;

   // w_src_*[k] is what feeds stage k: the ports for stage 0, the previous
   // stage's registers otherwise.
   logic [WIDTH-1:0]  w_src_a [STAGES];
   logic [WIDTH-1:0]  w_src_b [STAGES];
   logic [WIDTH-1:0]  w_src_s [STAGES];
   logic [WIDTH-1:0]  w_nxt_s [STAGES];
   logic [STAGES-1:0] w_src_c;
   logic [STAGES-1:0] w_src_v;
   logic [STAGES-1:0] w_cy;
   logic [CW-1:0]     w_chunk [STAGES];
   logic              w_adv;
   logic              w_cmsb;
   logic              w_ovf;

   assign w_adv    = !r_v[STAGES-1] || out_ready;
   assign in_ready = w_adv;

   always_comb begin
      w_src_a[0] = a;
      w_src_b[0] = sub ? ~b : b;
      w_src_c[0] = sub | cin;
      w_src_s[0] = '0;
      w_src_v[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_src_a[k] = r_a[k-1];
         w_src_b[k] = r_b[k-1];
         w_src_c[k] = r_c[k-1];
         w_src_s[k] = r_s[k-1];
         w_src_v[k] = r_v[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         {w_cy[k], w_chunk[k]} = {1'b0, w_src_a[k][k*CW +: CW]}
                               + {1'b0, w_src_b[k][k*CW +: CW]}
                               + {{CW{1'b0}}, w_src_c[k]};
         w_nxt_s[k]             = w_src_s[k];
         w_nxt_s[k][k*CW +: CW] = w_chunk[k];
      end
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      w_cmsb = w_src_a[STAGES-1][WIDTH-1] ^ w_src_b[STAGES-1][WIDTH-1]
             ^ w_nxt_s[STAGES-1][WIDTH-1];
      w_ovf  = w_cmsb ^ w_cy[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
         r_c   <= '0;
         r_v   <= '0;
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= w_src_a[k];
            r_b[k] <= w_src_b[k];
            r_s[k] <= w_nxt_s[k];
         end
         r_c   <= w_cy;
         r_v   <= w_src_v;
         r_ovf <= w_ovf;
      end
   end

   assign out_valid = r_v[STAGES-1];
   assign sum       = r_s[STAGES-1];
   assign cout      = r_c[STAGES-1];
   assign ovf       = r_ovf;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two-operand adder/subtractor that generalises our fixed 4-bit ripple adder. Any WIDTH is split into STAGES equal chunks, one chunk added per clock, with the carry registered between stages. The block has valid/ready handshakes on both sides, an add/subtract mode, carry-in, carry-out and signed-overflow flags. It is the arithmetic building block for the datapath accumulators and address generators.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4: pipeline depth, ≥1. Chunk width CW = WIDTH/STAGES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- a  in  WIDTH  operand A, unsigned or two's-complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: A+B+cin; 1: A−B, computed as A+~B+1.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of MSB; in sub mode 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational with no dependence on in_valid.
- Acceptance: an input is accepted when in_valid && in_ready.
- Stage 0:
  - Captures a and b, with b inverted when sub=1.
  - Effective carry-in is 1 when sub=1, otherwise cin.
  - Adds chunk 0 and registers the chunk result and carry.
  - Stage valid = in_valid at the time adv is high.
- Stage k (1..STAGES−1): adds chunk k of the delayed operands plus the registered carry from stage k−1. Lower result chunks and higher operand chunks travel forward in skew registers.
- Last stage: registers the full sum, cout and ovf. ovf is derived from the carry into bit WIDTH−1 and the carry out of it, both inside the top chunk.
- Register enables: every stage register, valid bits included, updates only when adv=1.
  - When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
  - Bubbles are not collapsed.
- Ordering: results leave in acceptance order. No transaction is dropped or duplicated.
- Mode binding: sub and cin are sampled with their operands and travel with that transaction. Mixed add/sub streams are legal back-to-back.
- STAGES=1: the whole add is done in one registered stage; behaviour is otherwise identical.

## Timing
- Reset (async on rst_n low): all stage valid bits, out_valid, sum, cout and ovf = 0. in_ready = 1 while in reset and on the first cycle after.
- Latency: with no stall, a transaction accepted on edge N is visible with out_valid=1 after edge N+STAGES−1, i.e. STAGES register stages.
- Throughput: 1 transaction/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - in_ready=0 and the whole pipeline freezes.
  - sum, cout and ovf stay stable.
- Release: on the first cycle out_ready=1, the held result is consumed and the pipe advances on the same edge.
- Reset mid-operation: every in-flight transaction is discarded. out_valid falls immediately (asynchronous). After release, the block behaves as if freshly reset.
- Simultaneous events: input acceptance and output consumption on the same edge are legal and required at full rate.

## Test plan
All scenarios use WIDTH=16, STAGES=4 unless noted.
- Basic add: a=0x1234, b=0x0FFF, sub=0, cin=0 → sum=0x2233, cout=0, ovf=0, out_valid high exactly 4 edges after acceptance.
- Carry chain across all chunks:
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1.
  - cin=1, 0x0001+0x0001 → 0x0003.
- Subtract:
  - 0x0005−0x0007 → 0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
  - sub=1 with cin=1 gives the same result as cin=0.
- Back-to-back with backpressure: 8 consecutive accepts (a=i, b=i, alternating sub), out_ready held low for 3 cycles mid-stream → all 8 results in order and correct, sum stable during the stall, in_ready=0 throughout the stall.
- Bubbles: in_valid pattern 1,0,0,1 with out_ready=1 → out_valid pattern 1,0,0,1 delayed by 4 cycles.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight → out_valid=0 immediately, no stale result after release. Repeat basic add with STAGES=1 and WIDTH=8 (0xFF+0x01 → 0x00, cout=1, latency 1).
